lfsr_param_gen: RTL and testbench
=================================

Name: lfsr_param_gen

Overview:
Parametrised maximal-length LFSR generator. It supersedes the fixed 16-bit test LFSR with configurable width and tap masks, and selects Fibonacci or Galois form at run time. It adds synchronous seed loading with zero-seed protection, a step counter and a period-complete pulse. It is used as a pseudo-random stimulus and pattern source in the project's test tops.

Parameters:
WIDTH, 16, register width in bits; legal 3..32.
FIB_TAPS, 16'hD008, Fibonacci tap mask. Bit i set means state[i] feeds the XOR. The default implements x^16+x^15+x^13+x^4+1.
GAL_POLY, 16'hA011, Galois feedback polynomial without the x^WIDTH term. Bit0 must be set.
RESET_SEED, 16'h0001, state after reset. Must be nonzero.

Ports:
i_Clk  input  1  clock, rising edge.
i_Rst  input  1  reset, asynchronous, active-low.
i_Enable  input  1  advance one step per cycle while high.
i_Seed_Load  input  1  single-cycle strobe that loads the seed.
i_Seed_Data  input  WIDTH  seed value, sampled when i_Seed_Load is high.
i_Mode  input  1  0 = Fibonacci, 1 = Galois. Sampled only at reset release or at seed load.
o_LFSR_Data  output  WIDTH  current state (registered).
o_LFSR_Done  output  1  one-cycle pulse when the state returns to the start value.
o_Count  output  WIDTH  steps taken since the last load.
o_Seed_Fixed  output  1  high when the last loaded seed was zero and was replaced.

Behaviour:
- Reset (i_Rst=0, asynchronous):
  - state=RESET_SEED, start=RESET_SEED.
  - mode_q=0 (Fibonacci). o_Count=0, o_LFSR_Done=0, o_Seed_Fixed=0.
  - Reset asserted mid-run aborts immediately. No output glitch beyond the asynchronous clear.
- Fibonacci step: fb = XOR-reduce(state & FIB_TAPS); next = {state[WIDTH-2:0], fb}.
- Galois step: next = {state[WIDTH-2:0],1'b0} XOR (state[WIDTH-1] ? GAL_POLY : 0).
- Load (i_Seed_Load=1): highest priority over i_Enable in the same cycle. No step is taken that cycle.
  - state=start=(i_Seed_Data==0 ? 1 : i_Seed_Data).
  - o_Seed_Fixed=(i_Seed_Data==0). It holds until the next load or reset.
  - mode_q=i_Mode, o_Count=0.
  - o_LFSR_Data shows the new seed on the following cycle.
- Step (i_Enable=1, no load): state=next; o_Count=o_Count+1. Latency is 1 cycle from enable to updated data.
- Hold (i_Enable=0): state and o_Count are frozen. o_LFSR_Done=0.
- Done: if a step produces next==start, then o_LFSR_Done=1 for exactly that cycle (registered with the state update) and o_Count wraps to 0 instead of incrementing. For maximal polynomials this fires every 2^WIDTH-1 enabled steps.
- A toggling enable only delays progress. Sequence order is independent of gaps.
- i_Mode changes outside a load are ignored.
- Parameter checks at elaboration (fatal):
  - WIDTH outside 3..32.
  - RESET_SEED==0.
  - GAL_POLY[0]==0.
  - FIB_TAPS[WIDTH-1]==0.
- All-zero state is unreachable, by construction through the reset and load rules.

Test Plan:
- Reset release with i_Enable=1 and default parameters (Fibonacci) -> o_LFSR_Data sequence 0x0001, 0x0002, 0x0004, 0x0008, 0x0011. o_Count 0, 1, 2, 3, 4.
- Load seed 0x8000 with i_Mode=1, then enable -> 0x8000, 0xA011, 0xE033. o_Seed_Fixed=0.
- Load seed 0x0000 -> o_LFSR_Data=0x0001 and o_Seed_Fixed=1. The next enabled step gives 0x0002 (Fibonacci).
- Run 65535 enabled steps from seed 0x0001 in each mode:
  - o_LFSR_Done pulses exactly once, on step 65535, with data 0x0001 and o_Count back to 0.
  - No repeated state occurs before that step.
  - 0x0000 never appears.
- Toggle i_Enable every cycle for 15 cycles, then hold 10 -> data advances only on enabled cycles. Values match the contiguous sequence, and data and count stay frozen during the hold.
- Load and enable together mid-run, then drop i_Rst mid-run -> the load wins with no step that cycle. Reset forces 0x0001, count 0 and Done 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_param_gen.sv
// lfsr_param_gen: run-time selectable Fibonacci/Galois LFSR with seed load, step count and period pulse
module lfsr_param_gen #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] FIB_TAPS   = 16'hD008,
  parameter logic [WIDTH-1:0] GAL_POLY   = 16'hA011,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'h0001
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enable,
  input  logic             i_Seed_Load,
  input  logic [WIDTH-1:0] i_Seed_Data,
  input  logic             i_Mode,
  output logic [WIDTH-1:0] o_LFSR_Data,
  output logic             o_LFSR_Done,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Seed_Fixed
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (WIDTH < 3 || WIDTH > 32) begin : g_chk_width
    $fatal(1, "lfsr_param_gen: WIDTH must be 3..32");
  end
  if (RESET_SEED == '0) begin : g_chk_seed
    $fatal(1, "lfsr_param_gen: RESET_SEED must be nonzero");
  end
  if (GAL_POLY[0] == 1'b0) begin : g_chk_gal
    $fatal(1, "lfsr_param_gen: GAL_POLY bit 0 must be set");
  end
  if (FIB_TAPS[WIDTH-1] == 1'b0) begin : g_chk_fib
    $fatal(1, "lfsr_param_gen: FIB_TAPS top bit must be set");
  end

  logic [WIDTH-1:0] state_q, state_d, start_q, start_d, count_q, count_d;
  logic [WIDTH-1:0] fib_next, gal_next, step_next, seed;
  logic             mode_q, mode_d, done_q, done_d, fixed_q, fixed_d, wrap, seed_zero;

  always_comb begin
    fib_next  = {state_q[WIDTH-2:0], ^(state_q & FIB_TAPS)};
    gal_next  = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? GAL_POLY : '0);
    step_next = mode_q ? gal_next : fib_next;
    seed_zero = (i_Seed_Data == '0);
    seed      = seed_zero ? ONE : i_Seed_Data;
    wrap      = (step_next == start_q);
    state_d   = i_Seed_Load ? seed : i_Enable ? step_next : state_q;
    start_d   = i_Seed_Load ? seed : start_q;
    mode_d    = i_Seed_Load ? i_Mode : mode_q;
    fixed_d   = i_Seed_Load ? seed_zero : fixed_q;
    done_d    = !i_Seed_Load && i_Enable && wrap;
    // A completed period restarts the count so it always reads steps since the start value.
    count_d   = i_Seed_Load ? '0 : !i_Enable ? count_q : wrap ? '0 : count_q + ONE;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= RESET_SEED;
      start_q <= RESET_SEED;
      count_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      fixed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      fixed_q <= fixed_d;
    end
  end

  assign o_LFSR_Data  = state_q;
  assign o_LFSR_Done  = done_q;
  assign o_Count      = count_q;
  assign o_Seed_Fixed = fixed_q;
endmodule

// File: tb/tb_lfsr_param_gen.sv
// tb_lfsr_param_gen: directed checks of lfsr_param_gen; a second instance fixed in Galois mode covers the full period in parallel
module tb_lfsr_param_gen;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, mode = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] data_f, cnt_f, data_g, cnt_g;
  logic        done_f, fixed_f, done_g, fixed_g;
  int          tests = 0, fails = 0;
  bit          seen_f [65536];
  bit          seen_g [65536];

  always #5 clk = ~clk;

  lfsr_param_gen dut_f (
    .i_Clk(clk), .i_Rst(rst_n), .i_Enable(en), .i_Seed_Load(load), .i_Seed_Data(seed),
    .i_Mode(mode), .o_LFSR_Data(data_f), .o_LFSR_Done(done_f), .o_Count(cnt_f), .o_Seed_Fixed(fixed_f)
  );

  lfsr_param_gen dut_g (
    .i_Clk(clk), .i_Rst(rst_n), .i_Enable(en), .i_Seed_Load(load), .i_Seed_Data(seed),
    .i_Mode(1'b1), .o_LFSR_Data(data_g), .o_LFSR_Done(done_g), .o_Count(cnt_g), .o_Seed_Fixed(fixed_g)
  );

  function automatic logic [15:0] fib(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hD008)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_d [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011};
    en = 1'b1;
    #12;
    tests++; if (data_f !== 16'h0001) begin fails++; $display("FAIL reset_data: got %h expected 0001", data_f); end
    tests++; if (cnt_f !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h expected 0000", cnt_f); end
    tests++; if (done_f !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_f); end
    tests++; if (fixed_f !== 1'b0) begin fails++; $display("FAIL reset_fixed: got %b expected 0", fixed_f); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (data_f !== exp_d[i]) begin fails++; $display("FAIL reset_seq_data[%0d]: got %h expected %h", i, data_f, exp_d[i]); end
      tests++; if (cnt_f !== 16'(i)) begin fails++; $display("FAIL reset_seq_count[%0d]: got %0d expected %0d", i, cnt_f, i); end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_galois_load();
    load = 1'b1; seed = 16'h8000; mode = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; mode = 1'b0;
    tests++; if (data_f !== 16'h8000) begin fails++; $display("FAIL gal_load_data: got %h expected 8000", data_f); end
    tests++; if (cnt_f !== 16'h0000) begin fails++; $display("FAIL gal_load_count: got %h expected 0000", cnt_f); end
    tests++; if (fixed_f !== 1'b0) begin fails++; $display("FAIL gal_load_fixed: got %b expected 0", fixed_f); end
    en = 1'b1;
    tick();
    tests++; if (data_f !== 16'hA011) begin fails++; $display("FAIL gal_step1: got %h expected a011", data_f); end
    tick();
    tests++; if (data_f !== 16'hE033) begin fails++; $display("FAIL gal_step2: got %h expected e033", data_f); end
    tests++; if (cnt_f !== 16'h0002) begin fails++; $display("FAIL gal_step2_count: got %h expected 0002", cnt_f); end
    en = 1'b0;
  endtask

  task automatic test_zero_seed();
    load = 1'b1; seed = 16'h0000; mode = 1'b0;
    tick();
    load = 1'b0;
    tests++; if (data_f !== 16'h0001) begin fails++; $display("FAIL zero_seed_data: got %h expected 0001", data_f); end
    tests++; if (fixed_f !== 1'b1) begin fails++; $display("FAIL zero_seed_fixed: got %b expected 1", fixed_f); end
    en = 1'b1;
    tick();
    en = 1'b0;
    tests++; if (data_f !== 16'h0002) begin fails++; $display("FAIL zero_seed_step: got %h expected 0002", data_f); end
    tests++; if (fixed_f !== 1'b1) begin fails++; $display("FAIL zero_seed_fixed_hold: got %b expected 1", fixed_f); end
  endtask

  task automatic test_toggle();
    logic [15:0] exp = 16'h0001;
    int ec = 0;
    load = 1'b1; seed = 16'h0001; mode = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      en = (i % 2 == 0);
      mode = ~mode;
      tick();
      if (en) begin exp = fib(exp); ec++; end
      tests++; if (data_f !== exp) begin fails++; $display("FAIL toggle_data[%0d]: got %h expected %h", i, data_f, exp); end
      tests++; if (cnt_f !== 16'(ec)) begin fails++; $display("FAIL toggle_count[%0d]: got %0d expected %0d", i, cnt_f, ec); end
    end
    en = 1'b0; mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (data_f !== exp || cnt_f !== 16'(ec)) begin fails++; $display("FAIL hold[%0d]: got %h/%0d expected %h/%0d", i, data_f, cnt_f, exp, ec); end
      tests++; if (done_f !== 1'b0) begin fails++; $display("FAIL hold_done[%0d]: got %b expected 0", i, done_f); end
    end
  endtask

  task automatic test_load_priority_and_reset();
    en = 1'b1;
    tick(); tick(); tick();
    load = 1'b1; seed = 16'h1234; mode = 1'b0;
    tick();
    load = 1'b0;
    tests++; if (data_f !== 16'h1234) begin fails++; $display("FAIL prio_data: got %h expected 1234", data_f); end
    tests++; if (cnt_f !== 16'h0000) begin fails++; $display("FAIL prio_count: got %h expected 0000", cnt_f); end
    tick();
    tests++; if (data_f !== fib(16'h1234)) begin fails++; $display("FAIL prio_step: got %h expected %h", data_f, fib(16'h1234)); end
    tests++; if (cnt_f !== 16'h0001) begin fails++; $display("FAIL prio_step_count: got %h expected 0001", cnt_f); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (data_f !== 16'h0001) begin fails++; $display("FAIL async_rst_data: got %h expected 0001", data_f); end
    tests++; if (cnt_f !== 16'h0000) begin fails++; $display("FAIL async_rst_count: got %h expected 0000", cnt_f); end
    tests++; if (done_f !== 1'b0) begin fails++; $display("FAIL async_rst_done: got %b expected 0", done_f); end
    #1;
    rst_n = 1'b1; en = 1'b0;
    tick();
  endtask

  task automatic test_full_period();
    seed = 16'h0001; load = 1'b1; mode = 1'b0; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    seen_f[1] = 1'b1; seen_g[1] = 1'b1;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      if (k < 65535) begin
        tests++; if (done_f !== 1'b0 || done_g !== 1'b0) begin fails++; if (fails < 50) $display("FAIL early_done[%0d]: got %b/%b expected 0/0", k, done_f, done_g); end
        tests++; if (cnt_f !== 16'(k) || cnt_g !== 16'(k)) begin fails++; if (fails < 50) $display("FAIL period_count[%0d]: got %0d/%0d expected %0d", k, cnt_f, cnt_g, k); end
        tests++; if (data_f == 16'h0000 || seen_f[data_f]) begin fails++; if (fails < 50) $display("FAIL fib_repeat[%0d]: got %h expected a new nonzero state", k, data_f); end
        tests++; if (data_g == 16'h0000 || seen_g[data_g]) begin fails++; if (fails < 50) $display("FAIL gal_repeat[%0d]: got %h expected a new nonzero state", k, data_g); end
        seen_f[data_f] = 1'b1; seen_g[data_g] = 1'b1;
      end else begin
        tests++; if (done_f !== 1'b1 || data_f !== 16'h0001 || cnt_f !== 16'h0000) begin fails++; $display("FAIL fib_wrap: got done=%b data=%h cnt=%h expected 1/0001/0000", done_f, data_f, cnt_f); end
        tests++; if (done_g !== 1'b1 || data_g !== 16'h0001 || cnt_g !== 16'h0000) begin fails++; $display("FAIL gal_wrap: got done=%b data=%h cnt=%h expected 1/0001/0000", done_g, data_g, cnt_g); end
      end
    end
    tick();
    en = 1'b0;
    tests++; if (done_f !== 1'b0 || data_f !== 16'h0002 || cnt_f !== 16'h0001) begin fails++; $display("FAIL fib_after_wrap: got done=%b data=%h cnt=%h expected 0/0002/0001", done_f, data_f, cnt_f); end
    tests++; if (done_g !== 1'b0 || data_g !== 16'h0002 || cnt_g !== 16'h0001) begin fails++; $display("FAIL gal_after_wrap: got done=%b data=%h cnt=%h expected 0/0002/0001", done_g, data_g, cnt_g); end
  endtask

  initial begin
    test_reset();
    test_galois_load();
    test_zero_seed();
    test_toggle();
    test_load_priority_and_reset();
    test_full_period();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
